video_timing_gen: RTL and testbench

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

---
 rtl/video_timing_gen.sv | 129 ++++++++++++
 tb/tb_video_timing_gen.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/video_timing_gen.sv
// video_timing_gen: free-running raster timing generator.
// A line/frame counter pair produces raw HS, VS, active-video and frame-start
// strobes. Those four are aligned to downstream pixel latency through a DLY-deep
// shift register, while the frame-buffer read enable (orden) stays undelayed so
// that data fetched with it arrives in step with the delayed ode.
// A mode toggle request is accumulated in a pending flag and applied only at a
// frame boundary, so omode is stable for a whole frame.
module video_timing_gen #(
  parameter int   H_TOTAL  = 1056,
  parameter int   H_SYNC   = 128,
  parameter int   H_BPORCH = 88,
  parameter int   H_RES    = 800,
  parameter int   V_TOTAL  = 628,
  parameter int   V_SYNC   = 4,
  parameter int   V_BPORCH = 23,
  parameter int   V_RES    = 600,
  parameter int   RD_HRES  = 640,
  parameter int   RD_VRES  = 480,
  parameter logic HS_POL   = 1'b1,
  parameter logic VS_POL   = 1'b1,
  parameter int   DLY      = 5
) (
  input  logic iclk,
  input  logic irst,
  input  logic imode_tgl,
  output logic orden,
  output logic ode,
  output logic ohs,
  output logic ovs,
  output logic oframe_start,
  output logic omode
);

  // Widths hold one past the last count so the exclusive end bounds fit.
  localparam int HW = $clog2(H_TOTAL + 1);
  localparam int VW = $clog2(V_TOTAL + 1);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_SYNCW = HW'(H_SYNC);
  localparam logic [VW-1:0] V_SYNCW = VW'(V_SYNC);
  localparam logic [HW-1:0] H_ACT_S = HW'(H_SYNC + H_BPORCH);
  localparam logic [HW-1:0] H_ACT_E = HW'(H_SYNC + H_BPORCH + H_RES);
  localparam logic [VW-1:0] V_ACT_S = VW'(V_SYNC + V_BPORCH);
  localparam logic [VW-1:0] V_ACT_E = VW'(V_SYNC + V_BPORCH + V_RES);
  // Read window is centred; an odd leftover pixel/line lands right/bottom
  // because the integer division rounds the leading offset down.
  localparam logic [HW-1:0] H_RD_S  = HW'(H_SYNC + H_BPORCH + (H_RES - RD_HRES) / 2);
  localparam logic [HW-1:0] H_RD_E  = HW'(H_SYNC + H_BPORCH + (H_RES - RD_HRES) / 2 + RD_HRES);
  localparam logic [VW-1:0] V_RD_S  = VW'(V_SYNC + V_BPORCH + (V_RES - RD_VRES) / 2);
  localparam logic [VW-1:0] V_RD_E  = VW'(V_SYNC + V_BPORCH + (V_RES - RD_VRES) / 2 + RD_VRES);

  // Delay-line bit layout: {frame_start, de, vs, hs}; idle value is inactive.
  localparam logic [3:0] DLY_IDLE = {1'b0, 1'b0, ~VS_POL, ~HS_POL};

  logic [HW-1:0] hcnt_q, hcnt_d;
  logic [VW-1:0] vcnt_q, vcnt_d;
  logic          pending_q, pending_d;
  logic          omode_q, omode_d;
  logic [3:0]    dly_q [DLY];
  logic [3:0]    dly_d [DLY];

  logic raw_hs, raw_vs, raw_de, raw_fs, h_act, v_act;

  // Raw strobes decoded straight from the counters.
  always_comb begin
    h_act  = (hcnt_q >= H_ACT_S) && (hcnt_q < H_ACT_E);
    v_act  = (vcnt_q >= V_ACT_S) && (vcnt_q < V_ACT_E);
    raw_hs = (hcnt_q < H_SYNCW) ? HS_POL : ~HS_POL;
    raw_vs = (vcnt_q < V_SYNCW) ? VS_POL : ~VS_POL;
    raw_de = h_act && v_act;
    raw_fs = (hcnt_q == '0) && (vcnt_q == '0);
    orden  = raw_de && (hcnt_q >= H_RD_S) && (hcnt_q < H_RD_E)
                    && (vcnt_q >= V_RD_S) && (vcnt_q < V_RD_E);
  end

  // Next-state for counters, mode/pending and the alignment delay line.
  always_comb begin
    hcnt_d    = hcnt_q;
    vcnt_d    = vcnt_q;
    pending_d = pending_q;
    omode_d   = omode_q;
    if (hcnt_q == H_LAST) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
    end else begin
      hcnt_d = hcnt_q + 1'b1;
    end
    // A toggle arriving exactly at frame start is folded into this frame.
    if (raw_fs) begin
      omode_d   = omode_q ^ pending_q ^ imode_tgl;
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q ^ imode_tgl;
    end
    dly_d[0] = {raw_fs, raw_de, raw_vs, raw_hs};
    for (int i = 1; i < DLY; i++) begin
      dly_d[i] = dly_q[i-1];
    end
  end

  // State registers; reset forces every stage to inactive levels.
  always_ff @(posedge iclk or posedge irst) begin
    if (irst) begin
      hcnt_q    <= '0;
      vcnt_q    <= '0;
      pending_q <= 1'b0;
      omode_q   <= 1'b0;
      for (int i = 0; i < DLY; i++) begin
        dly_q[i] <= DLY_IDLE;
      end
    end else begin
      hcnt_q    <= hcnt_d;
      vcnt_q    <= vcnt_d;
      pending_q <= pending_d;
      omode_q   <= omode_d;
      for (int i = 0; i < DLY; i++) begin
        dly_q[i] <= dly_d[i];
      end
    end
  end

  assign oframe_start = dly_q[DLY-1][3];
  assign ode          = dly_q[DLY-1][2];
  assign ovs          = dly_q[DLY-1][1];
  assign ohs          = dly_q[DLY-1][0];
  assign omode        = omode_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen with a 16x8 raster and DLY=3.
// Expected output vectors are queued when each clock's stimulus is driven and
// compared at the following falling edge.
module tb_video_timing_gen;

  logic iclk = 1'b0;
  logic irst = 1'b1;
  logic imode_tgl = 1'b0;
  logic orden, ode, ohs, ovs, oframe_start, omode;

  video_timing_gen #(
    .H_TOTAL(16), .H_SYNC(2), .H_BPORCH(2), .H_RES(10),
    .V_TOTAL(8), .V_SYNC(1), .V_BPORCH(1), .V_RES(5),
    .RD_HRES(6), .RD_VRES(3), .HS_POL(1'b1), .VS_POL(1'b1), .DLY(3)
  ) dut (
    .iclk(iclk), .irst(irst), .imode_tgl(imode_tgl),
    .orden(orden), .ode(ode), .ohs(ohs), .ovs(ovs),
    .oframe_start(oframe_start), .omode(omode)
  );

  // Clock: 10 time-unit period.
  always #5 iclk = ~iclk;

  int checks = 0;
  int errors = 0;
  logic [5:0] exp_q[$];
  int fs_edges[$];
  int k;
  logic m_mode, m_pend;
  int cnt_rden, cnt_de, cnt_hs;

  // Raw strobes at raster position p (clocks since reset release): {fs,de,vs,hs}.
  function automatic logic [3:0] raw_at(int p);
    int h, v;
    logic [3:0] r;
    if (p < 0) return 4'b0000;
    h = p % 16;
    v = (p / 16) % 8;
    r[0] = (h < 2);
    r[1] = (v < 1);
    r[2] = (h >= 4) && (h < 14) && (v >= 2) && (v < 7);
    r[3] = (p % 128 == 0);
    return r;
  endfunction

  // Read window: hcnt 6..11 on vcnt 3..5.
  function automatic logic rden_at(int p);
    int h, v;
    if (p < 0) return 1'b0;
    h = p % 16;
    v = (p / 16) % 8;
    return (h >= 6) && (h <= 11) && (v >= 3) && (v <= 5);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock: drive toggle, queue expectation for the edge, compare after it.
  // Vector layout: {orden, ode, ohs, ovs, oframe_start, omode}.
  task automatic step(input logic tgl);
    logic [3:0] r;
    logic [5:0] e, obs;
    imode_tgl = tgl;
    if (k % 128 == 0) begin
      m_mode = m_mode ^ m_pend ^ tgl;
      m_pend = 1'b0;
    end else begin
      m_pend = m_pend ^ tgl;
    end
    r = raw_at(k - 2);
    exp_q.push_back({rden_at(k + 1), r[2], r[0], r[1], r[3], m_mode});
    @(posedge iclk);
    @(negedge iclk);
    imode_tgl = 1'b0;
    e = exp_q.pop_front();
    obs = {orden, ode, ohs, ovs, oframe_start, omode};
    check($sformatf("cyc%0d", k), 32'(obs), 32'(e));
    if (orden) cnt_rden++;
    if (ode) cnt_de++;
    if (ohs) cnt_hs++;
    if (oframe_start) fs_edges.push_back(k);
    k++;
  endtask

  task automatic restart();
    k = 0;
    m_mode = 1'b0;
    m_pend = 1'b0;
    cnt_rden = 0;
    cnt_de = 0;
    cnt_hs = 0;
    fs_edges.delete();
  endtask

  initial begin
    restart();
    // Reset levels while irst is held.
    repeat (3) @(negedge iclk);
    check("reset_levels", 32'({orden, ode, ohs, ovs, oframe_start, omode}), 32'h0);
    irst = 1'b0;

    // Two frames: toggle mid-frame at hcnt=5,vcnt=2, then at frame start.
    while (k < 256) begin
      step(k == 37 || k == 256);
      if (k == 128) check("omode_before_fs", 32'(omode), 32'h0);
      if (k == 129) check("omode_at_fs", 32'(omode), 32'h1);
    end
    check("rden_per_2frames", 32'(cnt_rden), 32'd36);
    check("de_count", 32'(cnt_de), 32'd100);
    check("hs_count", 32'(cnt_hs), 32'd32);
    check("fs_pulses", 32'(fs_edges.size()), 32'd2);
    if (fs_edges.size() == 2) begin
      check("fs_first", 32'(fs_edges[0]), 32'd2);
      check("fs_period", 32'(fs_edges[1] - fs_edges[0]), 32'd128);
    end

    // Coincident toggle at 256, two cancelling toggles, then one more.
    while (k <= 551) begin
      step(k == 256 || k == 300 || k == 330 || k == 390);
      if (k == 257) check("omode_coincident", 32'(omode), 32'h0);
      if (k == 385) check("omode_cancel", 32'(omode), 32'h0);
    end
    check("omode_pre_reset", 32'(omode), 32'h1);
    check("ode_pre_reset", 32'(ode), 32'h1);

    // Asynchronous reset mid-frame, away from the clock edge.
    #2 irst = 1'b1;
    #1 check("async_reset", 32'({orden, ode, ohs, ovs, oframe_start, omode}), 32'h0);
    @(negedge iclk);
    @(negedge iclk);
    check("reset_hold", 32'({orden, ode, ohs, ovs, oframe_start, omode}), 32'h0);
    irst = 1'b0;
    restart();
    while (k < 140) step(1'b0);
    check("fs_after_rerst", 32'(fs_edges.size()), 32'd2);
    if (fs_edges.size() == 2) begin
      check("fs_first_rerst", 32'(fs_edges[0]), 32'd2);
      check("fs_period_rerst", 32'(fs_edges[1]), 32'd130);
    end
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Overall run bound.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
